decode_seq: RTL and testbench
=============================

Name: decode_seq

Overview:
- Parametrised, registered successor to the team's 4-to-16 combinational decoder.
- Accepts a binary code through a valid/ready handshake and drives a one-hot select bus.
- Three modes: level (latched), pulse (timed strobe) and scan (auto-walk from the code to the top output).
- Sits between control FSMs and banks of enables/chip-selects where glitch-free registered selects are required.

Parameters:
- IN_W, 4, width of the binary code input.
- NUM_OUT, 16, number of one-hot outputs; legal range 2 to 2**IN_W.
- HOLD_CYCLES, 4, cycles each one-hot value is held in pulse and scan modes; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  block enable; low aborts any activity.
- mode  input  2  00 = level, 01 = pulse, 10 = scan, 11 = treated as level.
- de_in  input  IN_W  binary code.
- in_valid  input  1  command present.
- in_ready  output  1  command can be accepted.
- de_out  output  NUM_OUT  registered one-hot select, or all-zero.
- busy  output  1  high in PULSE or SCAN.
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - On rst=1 at a clock edge: de_out=0, done=0, busy=0, state=IDLE, counters=0.
  - in_ready follows its equation after reset.
  - rst overrides every other input, including mid-pulse or mid-scan: no done is produced.
- Handshake:
  - in_ready = en && (state==IDLE || state==LEVEL), combinational from registered state.
  - A command is accepted when in_valid && in_ready at a clock edge; mode and de_in are sampled at that edge.
  - Latency: de_out reflects an accepted command on the first edge after acceptance (1 cycle).
- States IDLE, LEVEL, PULSE, SCAN:
  - IDLE: de_out=0. On accept, go to LEVEL, PULSE or SCAN per mode.
  - LEVEL:
    - de_out=onehot(de_in), held indefinitely.
    - A new accept overwrites de_out on the next edge; mode=01/10 moves to PULSE/SCAN.
    - No done is produced in this state.
  - PULSE:
    - de_out=onehot(code) for exactly HOLD_CYCLES cycles.
    - Then de_out=0 and done=1 for one cycle, coincident with the first zero cycle; state returns to IDLE.
  - SCAN:
    - Index i starts at code; de_out=onehot(i) for HOLD_CYCLES cycles, then i increments.
    - After the window for i=NUM_OUT-1: de_out=0, done=1 for one cycle, return to IDLE. No wrap-around.
    - Total active cycles = (NUM_OUT-code)*HOLD_CYCLES.
- en low:
  - Blocks acceptance.
  - In any state, the next edge gives de_out=0 and state=IDLE, with no done.
  - Abort takes priority over a completion on the same edge.
- busy = (state==PULSE || state==SCAN), registered with the state.
- Illegal code (de_in >= NUM_OUT, only possible when NUM_OUT < 2**IN_W):
  - Still handshaken.
  - Behaves as a clear: de_out=0, state=IDLE, no done.
- Hold counter: width clog2(HOLD_CYCLES+1); reloaded on every index change and every accept.
- de_out never has more than one bit set in any cycle.

Optional Feature:
- Macro DECODE_SEQ_ERR_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - An accepted illegal code pulses err=1 for exactly one cycle (the edge after acceptance).
  - The command is dropped: state and de_out stay unchanged (a LEVEL output is held).
- When undefined:
  - No err port.
  - An illegal code clears de_out to 0 and returns to IDLE, as described in Behaviour.

Test Plan:
- Level mode, defaults: accept mode=00 de_in=4'h5, then 4'hA -> de_out=16'h0020 one cycle after the first accept, 16'h0400 one cycle after the second; done never asserts; in_ready stays 1.
- Pulse mode, HOLD_CYCLES=4: accept mode=01 de_in=4'h3 -> de_out=16'h0008 for exactly 4 cycles; then 16'h0000 with done=1 for 1 cycle; busy=1 during the pulse and in_ready=0; in_valid held during the pulse is not accepted.
- Scan mode, HOLD_CYCLES=2: accept mode=10 de_in=4'hD -> de_out 16'h2000, 16'h4000, 16'h8000, 2 cycles each (6 cycles); then 0 with done=1; no wrap to 16'h0001.
- Abort: scan from 4'h0 with en dropped on cycle 5 -> de_out=0 on the next edge, state IDLE, done stays 0; the same sequence with rst=1 instead gives identical output.
- Illegal code, NUM_OUT=10, IN_W=4, LEVEL holding onehot(2): accept de_in=4'hC. Without macro -> de_out=0. With DECODE_SEQ_ERR_EN -> err=1 for 1 cycle and de_out stays 10'h004.
- One-hot check: random mode/code/en/in_valid for 10k cycles -> de_out is either 0 or has exactly one bit set, every cycle.

Source files
------------

// File: rtl/decode_seq.sv
// rtl/decode_seq.sv - registered binary-to-one-hot decoder with level, pulse and scan modes
//
// Purpose:
//   Accepts a binary code over a valid/ready handshake and drives a glitch-free
//   registered one-hot select bus. Three modes are supported:
//   level (latched), pulse (timed strobe) and scan (walk from code to top output).
//   Optional macro DECODE_SEQ_ERR_EN adds an err strobe.
//   With this macro, an illegal code is dropped instead of clearing the outputs.
//
// Parameters:
//   IN_W        width of the binary code
//   NUM_OUT     number of one-hot outputs (2 .. 2**IN_W)
//   HOLD_CYCLES cycles each one-hot value is held in pulse/scan (>= 1)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        block enable, low aborts any activity
//   mode      00 level, 01 pulse, 10 scan, 11 level
//   de_in     binary code
//   in_valid  command present
//   in_ready  command can be accepted (IDLE or LEVEL while enabled)
//   de_out    registered one-hot select, or all-zero
//   busy      high while in PULSE or SCAN
//   done      one-cycle completion strobe for pulse/scan
//   err       (DECODE_SEQ_ERR_EN only) one-cycle strobe on an accepted illegal code

module decode_seq #(
  parameter int IN_W        = 4,
  parameter int NUM_OUT     = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [IN_W-1:0]    de_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] de_out,
  output logic               busy,
  output logic               done
`ifdef DECODE_SEQ_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEVEL = 2'd1,
    S_PULSE = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IN_W-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_OUT-1:0] de_nxt;
  logic               done_nxt;
  logic               busy_nxt;
  logic               accept;
  logic               illegal;
  logic               last_hold;
  logic               last_idx;
`ifdef DECODE_SEQ_ERR_EN
  logic               err_nxt;
`endif

  function automatic logic [NUM_OUT-1:0] onehot(input logic [IN_W-1:0] i);
    return NUM_OUT'(1) << i;
  endfunction

  assign in_ready  = en && (state == S_IDLE || state == S_LEVEL);
  assign accept    = in_valid && in_ready;
  assign illegal   = 32'(de_in) >= NUM_OUT;
  // cnt holds the cycles left in the current window, including the present one
  assign last_hold = (cnt == CNT_W'(1));
  assign last_idx  = (32'(idx) == NUM_OUT - 1);

  // State register, together with the registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      de_out <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
`ifdef DECODE_SEQ_ERR_EN
      err    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      de_out <= de_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
`ifdef DECODE_SEQ_ERR_EN
      err    <= err_nxt;
`endif
    end
  end

  // Next-state logic; an abort (en low) wins over any completion on the same edge
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else if (accept) begin
      if (illegal) begin
`ifdef DECODE_SEQ_ERR_EN
        state_nxt = state;
`else
        state_nxt = S_IDLE;
`endif
      end else begin
        case (mode)
          2'b01:   state_nxt = S_PULSE;
          2'b10:   state_nxt = S_SCAN;
          default: state_nxt = S_LEVEL;
        endcase
      end
    end else begin
      case (state)
        S_PULSE: if (last_hold) state_nxt = S_IDLE;
        S_SCAN:  if (last_hold && last_idx) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Next-output logic: the values the output registers take on the coming edge
  always_comb begin
    de_nxt   = de_out;
    done_nxt = 1'b0;
    idx_nxt  = idx;
    cnt_nxt  = cnt;
`ifdef DECODE_SEQ_ERR_EN
    err_nxt  = 1'b0;
`endif
    if (!en) begin
      de_nxt  = '0;
      idx_nxt = '0;
      cnt_nxt = '0;
    end else if (accept) begin
      if (illegal) begin
`ifdef DECODE_SEQ_ERR_EN
        // Command dropped: outputs and counters hold, only err strobes
        err_nxt = 1'b1;
`else
        de_nxt  = '0;
        idx_nxt = '0;
        cnt_nxt = '0;
`endif
      end else begin
        de_nxt  = onehot(de_in);
        idx_nxt = de_in;
        cnt_nxt = CNT_W'(HOLD_CYCLES);
      end
    end else begin
      case (state)
        S_PULSE: begin
          if (last_hold) begin
            de_nxt   = '0;
            done_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_SCAN: begin
          if (last_hold) begin
            if (last_idx) begin
              // Top output finished: stop, no wrap-around to output 0
              de_nxt   = '0;
              done_nxt = 1'b1;
              cnt_nxt  = '0;
            end else begin
              idx_nxt = idx + IN_W'(1);
              de_nxt  = onehot(idx + IN_W'(1));
              cnt_nxt = CNT_W'(HOLD_CYCLES);
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          de_nxt = de_out;
        end
      endcase
    end
    busy_nxt = (state_nxt == S_PULSE) || (state_nxt == S_SCAN);
  end

endmodule

// File: tb/tb_decode_seq.sv
// tb/tb_decode_seq.sv - scoreboard testbench for decode_seq with a plan-queue reference model

module tb_decode_seq;

  localparam int IN_W    = 4;
  localparam int NUM_OUT = 10;
  localparam int HOLD    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [1:0]         mode;
  logic [IN_W-1:0]    de_in;
  logic               in_valid;
  logic               in_ready;
  logic [NUM_OUT-1:0] de_out;
  logic               busy;
  logic               done;
`ifdef DECODE_SEQ_ERR_EN
  logic               err;
`endif

  always #5 clk = ~clk;

  decode_seq #(
    .IN_W   (IN_W),
    .NUM_OUT(NUM_OUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .de_in   (de_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .de_out  (de_out),
    .busy    (busy),
    .done    (done)
`ifdef DECODE_SEQ_ERR_EN
    ,
    .err     (err)
`endif
  );

  typedef struct packed {
    logic [NUM_OUT-1:0] de;
    logic               done;
    logic               busy;
    logic               err;
    logic               ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   started = 1'b0;

  // Reference model: a sequence is a queue of one-hot values still to be shown
  logic [NUM_OUT-1:0] m_de     = '0;
  logic               m_done   = 1'b0;
  logic               m_err    = 1'b0;
  logic               m_active = 1'b0;
  logic [NUM_OUT-1:0] plan[$];

  function automatic logic [NUM_OUT-1:0] oh(input int i);
    logic [NUM_OUT-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle, got, expv);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic v,
                            input logic [1:0] md, input logic [IN_W-1:0] c);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r || !e) begin
      m_de     = '0;
      m_active = 1'b0;
      plan.delete();
    end else if (v && !m_active) begin
      if (int'(c) >= NUM_OUT) begin
`ifdef DECODE_SEQ_ERR_EN
        m_err = 1'b1;
`else
        m_de = '0;
`endif
      end else if (md == 2'b01 || md == 2'b10) begin
        plan.delete();
        if (md == 2'b01) begin
          repeat (HOLD) plan.push_back(oh(int'(c)));
        end else begin
          for (int i = int'(c); i < NUM_OUT; i++)
            repeat (HOLD) plan.push_back(oh(i));
        end
        m_de     = plan.pop_front();
        m_active = 1'b1;
      end else begin
        m_de = oh(int'(c));
      end
    end else if (m_active) begin
      if (plan.size() > 0) begin
        m_de = plan.pop_front();
      end else begin
        m_de     = '0;
        m_done   = 1'b1;
        m_active = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected response, then advance the model
  task automatic apply(input logic r, input logic e, input logic v,
                       input logic [1:0] md, input logic [IN_W-1:0] c);
    exp_t x;
    rst = r; en = e; in_valid = v; mode = md; de_in = c;
    if (started) begin
      x.de    = m_de;
      x.done  = m_done;
      x.busy  = m_active;
      x.err   = m_err;
      x.ready = e && !m_active;
      exp_q.push_back(x);
    end
    @(posedge clk);
    model_step(r, e, v, md, c);
    started = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 1'b1, 1'b0, 2'b00, '0);
  endtask

  exp_t mon_x;
  always @(negedge clk) begin
    cycle++;
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      check("de_out",   64'(de_out),   64'(mon_x.de));
      check("done",     64'(done),     64'(mon_x.done));
      check("busy",     64'(busy),     64'(mon_x.busy));
      check("in_ready", 64'(in_ready), 64'(mon_x.ready));
`ifdef DECODE_SEQ_ERR_EN
      check("err",      64'(err),      64'(mon_x.err));
`endif
      check("onehot",   64'($countones(de_out) <= 1), 64'(1));
    end
  end

  initial begin
    apply(1'b1, 1'b0, 1'b0, 2'b00, '0);
    apply(1'b1, 1'b0, 1'b0, 2'b00, '0);
    idle(2);

    // Level mode: two codes back to back, then mode 11 treated as level
    apply(1'b0, 1'b1, 1'b1, 2'b00, 4'h5);
    idle(2);
    apply(1'b0, 1'b1, 1'b1, 2'b00, 4'h3);
    idle(2);
    apply(1'b0, 1'b1, 1'b1, 2'b11, 4'h7);
    idle(1);

    // Pulse mode with in_valid held throughout: only accepted again after completion
    apply(1'b0, 1'b1, 1'b1, 2'b01, 4'h3);
    repeat (HOLD + 2) apply(1'b0, 1'b1, 1'b1, 2'b00, 4'h1);
    apply(1'b0, 1'b0, 1'b0, 2'b00, '0);
    idle(1);

    // Scan near the top, and a scan starting on the top output
    apply(1'b0, 1'b1, 1'b1, 2'b10, 4'h7);
    idle(3 * HOLD + 3);
    apply(1'b0, 1'b1, 1'b1, 2'b10, 4'(NUM_OUT - 1));
    idle(HOLD + 3);

    // Abort by en low mid-scan, then the same sequence aborted by rst
    apply(1'b0, 1'b1, 1'b1, 2'b10, 4'h0);
    idle(4);
    apply(1'b0, 1'b0, 1'b0, 2'b00, '0);
    idle(3);
    apply(1'b0, 1'b1, 1'b1, 2'b10, 4'h0);
    idle(4);
    apply(1'b1, 1'b1, 1'b0, 2'b00, '0);
    idle(3);

    // Abort on the completion edge of a pulse
    apply(1'b0, 1'b1, 1'b1, 2'b01, 4'h2);
    idle(HOLD - 1);
    apply(1'b0, 1'b0, 1'b0, 2'b00, '0);
    idle(2);

    // Illegal code while LEVEL holds onehot(2), and from IDLE
    apply(1'b0, 1'b1, 1'b1, 2'b00, 4'h2);
    idle(1);
    apply(1'b0, 1'b1, 1'b1, 2'b00, 4'hC);
    idle(2);
    apply(1'b0, 1'b0, 1'b0, 2'b00, '0);
    apply(1'b0, 1'b1, 1'b1, 2'b01, 4'hF);
    idle(2);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      apply(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 99) < 94),
            1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
    end
    idle(2);

    @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
